// File: rtl/cacheline_adaptor_if.sv
// Bus bundle between the arbiter main-memory port, the cacheline adaptor and
// physical memory. The adaptor takes the slave view; the environment the master view.
interface cacheline_adaptor_if;
    // Arbiter side
    logic [255:0] line_i;
    logic [255:0] line_o;
    logic [31:0]  address_i;
    logic         read_i;
    logic         write_i;
    logic         resp_o;
    // Physical memory side
    logic [63:0]  burst_i;
    logic [63:0]  burst_o;
    logic [31:0]  address_o;
    logic         read_o;
    logic         write_o;
    logic         resp_i;

    modport slave (
        input  line_i, address_i, read_i, write_i, burst_i, resp_i,
        output line_o, resp_o, burst_o, address_o, read_o, write_o
    );

    modport master (
        output line_i, address_i, read_i, write_i, burst_i, resp_i,
        input  line_o, resp_o, burst_o, address_o, read_o, write_o
    );
endinterface

// File: rtl/cacheline_adaptor.sv
// Cacheline adaptor: converts 256-bit line reads/writes from the arbiter into
// 4-beat 64-bit bursts to physical memory, and reassembles read beats into a line.
module cacheline_adaptor (
    input logic                 clk,
    input logic                 rst,
    cacheline_adaptor_if.slave  bus
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] READ  = 2'd1;
    localparam logic [1:0] WRITE = 2'd2;
    localparam logic [1:0] DONE  = 2'd3;

    logic [1:0]   state_q, state_d;
    logic [1:0]   cnt_q, cnt_d;
    logic [31:0]  addr_q, addr_d;
    logic [255:0] wline_q, wline_d;
    logic [255:0] rline_q, rline_d;

    // Next-state: requests are only sampled in IDLE, beats only counted in READ/WRITE.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        wline_d = wline_q;
        rline_d = rline_q;
        unique case (state_q)
            IDLE: begin
                // Write wins when both requests arrive together.
                if (bus.write_i) begin
                    wline_d = bus.line_i;
                    addr_d  = bus.address_i;
                    cnt_d   = 2'd0;
                    state_d = WRITE;
                end else if (bus.read_i) begin
                    addr_d  = bus.address_i;
                    cnt_d   = 2'd0;
                    state_d = READ;
                end
            end
            READ: begin
                if (bus.resp_i) begin
                    rline_d[{cnt_q, 6'd0} +: 64] = bus.burst_i;
                    cnt_d = cnt_q + 2'd1;
                    if (cnt_q == 2'd3) begin
                        state_d = DONE;
                    end
                end
            end
            WRITE: begin
                if (bus.resp_i) begin
                    cnt_d = cnt_q + 2'd1;
                    if (cnt_q == 2'd3) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State registers with synchronous reset; reset also discards a partial read line.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= 2'd0;
            addr_q  <= 32'd0;
            wline_q <= 256'd0;
            rline_q <= 256'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wline_q <= wline_d;
            rline_q <= rline_d;
        end
    end

    // Outputs decoded from the registered state; bus fields are zero when not in use.
    always_comb begin
        bus.line_o    = rline_q;
        bus.resp_o    = 1'b0;
        bus.read_o    = 1'b0;
        bus.write_o   = 1'b0;
        bus.address_o = 32'd0;
        bus.burst_o   = 64'd0;
        unique case (state_q)
            READ: begin
                bus.read_o    = 1'b1;
                bus.address_o = {addr_q[31:5], 5'd0};
            end
            WRITE: begin
                bus.write_o   = 1'b1;
                bus.address_o = {addr_q[31:5], 5'd0};
                bus.burst_o   = wline_q[{cnt_q, 6'd0} +: 64];
            end
            DONE: begin
                bus.resp_o = 1'b1;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_cacheline_adaptor.sv
// Self-checking bench for cacheline_adaptor: randomized line transfers against a
// memory model, with a queue of expected transactions checked by a separate monitor.
module tb_cacheline_adaptor;

    logic clk;
    logic rst;

    cacheline_adaptor_if bus ();

    cacheline_adaptor dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit           is_write;
        logic [31:0]  addr;
        logic [255:0] data;
    } txn_t;

    txn_t         exp_q[$];
    int           compared = 0;
    int           mismatched = 0;
    logic [63:0]  mem_beats[4];
    int           mem_mode = 1;     // 0 random stalls, 1 zero-wait, 2 two stalls per beat
    bit           mem_spur = 0;     // random resp_i while memory is not requested
    int           stall = 0;
    int           acks = 0;         // beats accepted in the current burst
    int           mon_beat = 0;
    bit           prev_resp = 0;
    logic [255:0] exp_line = '0;
    logic [255:0] sh;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [255:0] rand256();
        return {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    endfunction

    // Physical memory model: drives resp_i/burst_i just after each rising edge.
    initial begin
        bus.resp_i  = 1'b0;
        bus.burst_i = '0;
        forever begin
            @(posedge clk);
            #1;
            if (bus.read_o || bus.write_o) begin
                case (mem_mode)
                    0: bus.resp_i = ($urandom_range(0, 2) != 0);
                    1: bus.resp_i = 1'b1;
                    default: begin
                        bus.resp_i = (stall == 2);
                        stall = bus.resp_i ? 0 : stall + 1;
                    end
                endcase
                bus.burst_i = (acks < 4) ? mem_beats[acks] : {$urandom, $urandom};
            end else begin
                bus.resp_i  = mem_spur ? 1'($urandom_range(0, 1)) : 1'b0;
                bus.burst_i = {$urandom, $urandom};
                stall = 0;
            end
        end
    end

    // Beat counter of the memory model: a beat is taken when resp_i meets a request.
    always @(negedge clk) begin
        if (rst || !(bus.read_o || bus.write_o)) acks = 0;
        else if (bus.resp_i) acks = acks + 1;
    end

    // Monitor: checks every cycle against the head of the expected-transaction queue.
    always @(negedge clk) begin
        if (rst) begin
            mon_beat  = 0;
            prev_resp = 0;
            exp_line  = '0;
            exp_q.delete();
        end else begin
            if (bus.read_o || bus.write_o) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_request", {bus.read_o, bus.write_o}, 2'b00);
                end else begin
                    chk("direction", {bus.read_o, bus.write_o},
                        {!exp_q[0].is_write, exp_q[0].is_write});
                    chk("address_o", bus.address_o, {exp_q[0].addr[31:5], 5'd0});
                    if (mon_beat > 3) begin
                        chk("extra_beat", mon_beat, 3);
                    end else if (bus.write_o) begin
                        sh = exp_q[0].data >> (64 * mon_beat);
                        chk("burst_o", bus.burst_o, sh[63:0]);
                    end
                    if (bus.resp_i) mon_beat++;
                end
            end else begin
                chk("idle_address_o", bus.address_o, 32'd0);
                chk("idle_burst_o", bus.burst_o, 64'd0);
            end
            if (bus.resp_o) begin
                chk("resp_one_cycle", prev_resp, 1'b0);
                if (exp_q.size() == 0) begin
                    chk("spurious_resp", bus.resp_o, 1'b0);
                end else begin
                    chk("beat_count", mon_beat, 4);
                    if (!exp_q[0].is_write) begin
                        chk("line_o", bus.line_o, exp_q[0].data);
                        exp_line = exp_q[0].data;
                    end
                    void'(exp_q.pop_front());
                end
                mon_beat = 0;
            end
            prev_resp = bus.resp_o;
            if (!bus.read_o) chk("line_o_hold", bus.line_o, exp_line);
        end
    end

    // kind: 0 read, 1 write, 2 read+write together (write expected).
    // Entered and left just after a rising edge.
    task automatic run_txn(input int kind, input logic [31:0] addr, input logic [255:0] data,
                           input bit hold, input int mode, output int lat);
        txn_t t;
        bit   done;
        mem_mode = mode;
        for (int i = 0; i < 4; i++) mem_beats[i] = data[64*i +: 64];
        t.is_write = (kind != 0);
        t.addr     = addr;
        t.data     = data;
        exp_q.push_back(t);
        bus.address_i = addr;
        bus.line_i    = (kind != 0) ? data : rand256();
        bus.read_i    = (kind != 1);
        bus.write_i   = (kind != 0);
        lat  = 0;
        done = 0;
        while (!done && lat < 300) begin
            @(negedge clk);
            lat++;
            if (bus.resp_o) begin
                done = 1;
            end else begin
                @(posedge clk);
                #1;
                // Scramble arbiter inputs: the latched copies must be used.
                bus.address_i = $urandom;
                bus.line_i    = rand256();
            end
        end
        if (!done) begin
            chk("resp_timeout", 1'b0, 1'b1);
            rst = 1'b1;
        end
        if (!hold) begin
            bus.read_i  = 1'b0;
            bus.write_i = 1'b0;
        end
        @(posedge clk);
        #1;
        rst         = 1'b0;
        bus.read_i  = 1'b0;
        bus.write_i = 1'b0;
        repeat ($urandom_range(0, 3)) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Start a transfer, then reset after its second accepted beat.
    task automatic run_abort(input int kind, input int mode);
        txn_t t;
        logic [255:0] data;
        int n;
        data = rand256();
        mem_mode = mode;
        for (int i = 0; i < 4; i++) mem_beats[i] = data[64*i +: 64];
        t.is_write = (kind != 0);
        t.addr     = $urandom;
        t.data     = data;
        exp_q.push_back(t);
        bus.address_i = t.addr;
        bus.line_i    = data;
        bus.read_i    = (kind == 0);
        bus.write_i   = (kind != 0);
        n = 0;
        while (acks < 2 && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (acks < 2) chk("abort_beats_timeout", acks, 2);
        rst         = 1'b1;
        bus.read_i  = 1'b0;
        bus.write_i = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (3) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        int lat;
        rst           = 1'b1;
        bus.line_i    = '0;
        bus.address_i = '0;
        bus.read_i    = 1'b0;
        bus.write_i   = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        // Reset state observed while rst is still high after a few edges.
        chk("reset_line_o", bus.line_o, 256'd0);
        chk("reset_outputs", {bus.resp_o, bus.read_o, bus.write_o}, 3'b000);
        chk("reset_address_o", bus.address_o, 32'd0);
        rst = 1'b0;

        // Read issued on the first edge out of reset, zero-wait memory.
        run_txn(0, 32'h0000_1234,
                {{4{16'h4444}}, {4{16'h3333}}, {4{16'h2222}}, {4{16'h1111}}}, 0, 1, lat);
        chk("read_latency", lat, 6);

        // Write with two stall cycles ahead of every beat.
        run_txn(1, $urandom, rand256(), 0, 2, lat);

        // Read and write requested together: write only, same latency as a read.
        run_txn(2, $urandom, rand256(), 0, 1, lat);
        chk("write_latency", lat, 6);

        // Requests held high through DONE must not start a second transfer.
        run_txn(0, $urandom, rand256(), 1, 0, lat);
        run_txn(1, $urandom, rand256(), 1, 0, lat);

        // Reset in the middle of a read and of a write, then normal transfers.
        run_abort(0, 1);
        run_txn(0, $urandom, rand256(), 0, 1, lat);
        run_abort(1, 0);
        run_txn(1, $urandom, rand256(), 0, 0, lat);

        // Spurious resp_i while idle, then a read.
        mem_spur = 1;
        repeat (5) begin
            @(posedge clk);
            #1;
        end
        run_txn(0, $urandom, rand256(), 0, 0, lat);

        // Randomized mix.
        for (int i = 0; i < 40; i++) begin
            mem_spur = 1'($urandom_range(0, 1));
            run_txn($urandom_range(0, 2), $urandom, rand256(), 1'($urandom_range(0, 1)),
                    $urandom_range(0, 2), lat);
            if (mem_mode == 1) chk("random_latency", lat, 6);
        end
        mem_spur = 0;
        repeat (5) begin
            @(posedge clk);
            #1;
        end
        chk("queue_drained", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/cacheline_adaptor.md
CACHELINE_ADAPTOR -- requirements
Module: cacheline_adaptor

Interface
REQ-001 Parameters: none; line width fixed 256 bits, burst width 64 bits, 4 beats per line.
REQ-002 clk  input  1  clock; all state changes on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 line_i  input  256  write line from arbiter main-memory port.
REQ-005 line_o  output  256  assembled read line to arbiter.
REQ-006 address_i  input  32  line request address from arbiter.
REQ-007 read_i  input  1  line read request, held until resp_o.
REQ-008 write_i  input  1  line write request, held until resp_o.
REQ-009 resp_o  output  1  one-cycle line completion pulse to arbiter.
REQ-010 burst_i  input  64  read beat data from physical memory.
REQ-011 burst_o  output  64  write beat data to physical memory.
REQ-012 address_o  output  32  line-aligned address to physical memory.
REQ-013 read_o  output  1  burst read request to physical memory.
REQ-014 write_o  output  1  burst write request to physical memory.
REQ-015 resp_i  input  1  per-beat acknowledge from physical memory.

Function
REQ-016 States SHALL be IDLE, READ, WRITE, DONE; 2-bit beat counter cnt.
REQ-017 IDLE: if write_i, latch line_i and address_i, cnt<=0, go WRITE; else if read_i, latch address_i, cnt<=0, go READ; else stay.
REQ-018 Simultaneous read_i and write_i in IDLE SHALL select WRITE; the read is not serviced.
REQ-019 address_o SHALL be {latched_addr[31:5],5'b0} in READ/WRITE, 0 otherwise.
REQ-020 READ: read_o=1 every cycle; on resp_i=1 store burst_i into line_o[64*cnt +: 64], cnt<=cnt+1.
REQ-021 READ: resp_i=1 with cnt==3 SHALL store final beat and go DONE; resp_i=0 holds state, cnt, data.
REQ-022 WRITE: write_o=1 every cycle, burst_o=latched_line[64*cnt +: 64]; on resp_i=1 cnt<=cnt+1.
REQ-023 WRITE: resp_i=1 with cnt==3 SHALL go DONE; burst_o=0 outside WRITE.
REQ-024 DONE: resp_o=1 for exactly one cycle, read_o=write_o=0, then IDLE unconditionally.
REQ-025 Requests SHALL be sampled only in IDLE; read_i/write_i still high in DONE SHALL not start a new transfer.
REQ-026 line_o SHALL be registered, updated only by READ beats, stable from DONE until the next READ's first beat.
REQ-027 resp_i in IDLE or DONE SHALL be ignored (no counter, data, or state change).
REQ-028 Read latency: resp_o asserted the cycle after the 4th accepted beat; zero-wait memory gives resp_o 6 cycles after request sampled in IDLE (edge count: IDLE->READ, 4 beats, DONE).
REQ-029 Write latency identical to read under identical resp_i timing.
REQ-030 address_i/line_i changes after latch SHALL not affect an in-flight transfer.

Reset
REQ-031 rst=1 SHALL force IDLE, cnt=0, line_o=0, latched address/line=0, resp_o=read_o=write_o=0 next edge.
REQ-032 rst asserted mid-READ or mid-WRITE SHALL abort without resp_o; partial line_o contents cleared to 0.
REQ-033 First request SHALL be sampled on the first edge with rst=0.

Verification
REQ-034 Read, zero-wait: read_i, address_i=0x0000_1234, beats 0x11..11, 0x22..22, 0x33..33, 0x44..44 -> address_o=0x0000_1220, line_o={0x44..,0x33..,0x22..,0x11..}, one resp_o pulse.
REQ-035 Write with stalls: write_i, line_i={D3,D2,D1,D0}, resp_i low 2 cycles between beats -> burst_o D0,D1,D2,D3 in order, each held until acked, write_o high throughout, one resp_o.
REQ-036 Simultaneous read_i=write_i=1 -> WRITE performed, read_o never asserted.
REQ-037 Request held high through DONE -> exactly one resp_o, no second transfer starts.
REQ-038 rst after 2nd read beat -> IDLE, line_o=0, no resp_o; next read completes normally.
REQ-039 Spurious resp_i in IDLE then read -> line_o contains only the 4 in-transfer beats, cnt unaffected.
